// File: rtl/clock_divider.sv
`default_nettype none
//============================================================================
// Module   : clock_divider
// Purpose  : Multi-channel runtime-programmable clock divider / tick
//            generator. Each channel owns a double-buffered divisor, an
//            enable, a 50%-duty divided clock and a one-cycle tick strobe.
//            New divisors take effect only at a period boundary (wrap,
//            sync, or while the channel is idle) so the outputs never glitch.
// Revision : 1.0 - initial parametrised multi-channel release
//============================================================================
module clock_divider #(
  parameter int          NUM_CH        = 2,
  parameter int          COUNTER_WIDTH = 13,
  parameter int unsigned RESET_DIV     = 624,
  localparam int         CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_en,
  input  logic                     i_wr,
  input  logic [CH_W-1:0]          i_wr_ch,
  input  logic [COUNTER_WIDTH-1:0] i_wr_div,
  input  logic                     i_sync,
  output logic [NUM_CH-1:0]        o_clk,
  output logic [NUM_CH-1:0]        o_tick,
  output logic [NUM_CH-1:0]        o_pending
);

  localparam logic [COUNTER_WIDTH-1:0] c_reset_div = RESET_DIV[COUNTER_WIDTH-1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic [COUNTER_WIDTH-1:0] r_div_active;
    logic [COUNTER_WIDTH-1:0] r_div_shadow;
    logic                     r_pending;
    logic                     r_clk;
    logic                     r_tick;

    logic w_wr_hit;
    logic w_wrap;
    logic w_load;

    // A write aimed at a channel index that does not exist never matches,
    // so out-of-range writes leave every channel untouched.
    assign w_wr_hit = i_wr && (i_wr_ch == CH_W'(c));

    // The counter never exceeds the active divisor, so equality is the wrap.
    assign w_wrap   = (r_cnt == r_div_active);

    // A pending shadow becomes active on sync, on an enabled wrap, or on
    // the first idle cycle of a disabled channel. The value loaded is the
    // shadow as it stood before this cycle's write, so a write that lands
    // on the activation cycle stays pending for the next boundary.
    assign w_load   = r_pending && (i_sync || !i_en[c] || w_wrap);

    // Counter and output generation: sync restarts phase, enabled channels
    // count and toggle on wrap, disabled channels hold (restart on reload).
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (i_sync) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (i_en[c]) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
        if (r_pending) begin
          r_cnt <= '0;
        end
      end
    end

    // Divisor double buffer: writes always land in the shadow; the shadow
    // moves to the active divisor only at a boundary selected by w_load.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_div_active <= c_reset_div;
        r_div_shadow <= c_reset_div;
        r_pending    <= 1'b0;
      end else begin
        if (w_load) begin
          r_div_active <= r_div_shadow;
        end
        if (w_wr_hit) begin
          r_div_shadow <= i_wr_div;
          r_pending    <= 1'b1;
        end else if (w_load) begin
          r_pending    <= 1'b0;
        end
      end
    end

    assign o_clk[c]     = r_clk;
    assign o_tick[c]    = r_tick;
    assign o_pending[c] = r_pending;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
//============================================================================
// Module   : tb_clock_divider
// Purpose  : Scoreboard bench for clock_divider. A period-level reference
//            model predicts every cycle's outputs; a monitor compares them.
// Revision : 1.0 - initial release
//============================================================================
module tb_clock_divider;

  localparam int NUM_CH = 2;
  localparam int CW     = 13;
  localparam int RD     = 624;
  localparam int CH_W   = 1;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [NUM_CH-1:0] i_en  = '0;
  logic              i_wr  = 1'b0;
  logic [CH_W-1:0]   i_wr_ch = '0;
  logic [CW-1:0]     i_wr_div = '0;
  logic              i_sync = 1'b0;
  logic [NUM_CH-1:0] o_clk;
  logic [NUM_CH-1:0] o_tick;
  logic [NUM_CH-1:0] o_pending;

  clock_divider #(
    .NUM_CH       (NUM_CH),
    .COUNTER_WIDTH(CW),
    .RESET_DIV    (RD)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_wr     (i_wr),
    .i_wr_ch  (i_wr_ch),
    .i_wr_div (i_wr_div),
    .i_sync   (i_sync),
    .o_clk    (o_clk),
    .o_tick   (o_tick),
    .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   running  = 1'b0;

  // Reference model in period terms: elapsed enabled cycles in the current
  // period, period length in cycles (divisor+1), and the staged period.
  int m_elapsed [NUM_CH];
  int m_period  [NUM_CH];
  int m_staged  [NUM_CH];
  bit m_pend    [NUM_CH];
  bit m_lvl     [NUM_CH];
  bit m_tick    [NUM_CH];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit sync, input bit wr,
                            input int wr_ch, input int wr_div,
                            input logic [NUM_CH-1:0] en);
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        m_elapsed[c] = 0;
        m_period[c]  = RD + 1;
        m_staged[c]  = RD + 1;
        m_pend[c]    = 0;
        m_lvl[c]     = 0;
        m_tick[c]    = 0;
      end else begin
        bit boundary;
        boundary = 0;
        if (sync) begin
          m_elapsed[c] = 0;
          m_lvl[c]     = 0;
          m_tick[c]    = 0;
          boundary     = 1;
        end else if (en[c]) begin
          if (m_elapsed[c] + 1 == m_period[c]) begin
            m_elapsed[c] = 0;
            m_lvl[c]     = !m_lvl[c];
            m_tick[c]    = 1;
            boundary     = 1;
          end else begin
            m_elapsed[c] = m_elapsed[c] + 1;
            m_tick[c]    = 0;
          end
        end else begin
          m_tick[c] = 0;
          if (m_pend[c]) begin
            m_elapsed[c] = 0;
            boundary     = 1;
          end
        end
        if (boundary && m_pend[c]) begin
          m_period[c] = m_staged[c];
          m_pend[c]   = 0;
        end
        if (wr && wr_ch == c) begin
          m_staged[c] = wr_div + 1;
          m_pend[c]   = 1;
        end
      end
      e.clk[c]  = m_lvl[c];
      e.tick[c] = m_tick[c];
      e.pend[c] = m_pend[c];
    end
    exp_q.push_back(e);
  endtask

  // One stimulus cycle: drive on the falling edge and record the expected
  // state after the following rising edge.
  task automatic cycle(input logic [NUM_CH-1:0] en, input bit wr, input int wr_ch,
                       input int wr_div, input bit sync, input bit rst);
    @(negedge i_clk);
    i_en     = en;
    i_wr     = wr;
    i_wr_ch  = CH_W'(wr_ch);
    i_wr_div = CW'(wr_div);
    i_sync   = sync;
    i_rst    = rst;
    running  = 1'b1;
    model_step(rst, sync, wr, wr_ch, wr_div, en);
  endtask

  task automatic run(input logic [NUM_CH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(en, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_now();
    #1;
    check("async_rst_clk", int'(o_clk), 0);
    check("async_rst_tick", int'(o_tick), 0);
    check("async_rst_pend", int'(o_pending), 0);
  endtask

  // Monitor: every rising edge the DUT presents a new output set.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("o_clk", int'(o_clk), int'(e.clk));
        check("o_tick", int'(o_tick), int'(e.tick));
        check("o_pending", int'(o_pending), int'(e.pend));
      end else if (running) begin
        check("scoreboard_underrun", 0, 1);
      end
    end
  end

  initial begin
    // Reset and default divisor: first rise at edge 625.
    for (int k = 0; k < 3; k++) cycle(2'b11, 0, 0, 0, 0, 1);
    run(2'b11, 1300);

    // Mid-period write to ch1, D=3.
    cycle(2'b11, 1, 1, 3, 0, 0);
    run(2'b11, 700);

    // D=0 on ch0 followed by sync.
    cycle(2'b11, 1, 0, 0, 0, 0);
    cycle(2'b11, 0, 0, 0, 1, 0);
    run(2'b11, 20);

    // Two writes before a wrap: last one (9) wins.
    cycle(2'b11, 1, 1, 5, 0, 0);
    cycle(2'b11, 1, 1, 9, 0, 0);
    run(2'b11, 45);

    // Disable ch1 mid-count for 50 cycles, then resume.
    run(2'b11, 3);
    run(2'b01, 50);
    run(2'b11, 40);

    // Write while disabled: clean restart with the new divisor.
    cycle(2'b01, 1, 1, 2, 0, 0);
    run(2'b01, 5);
    run(2'b11, 20);

    // Asynchronous reset mid-period, checked immediately.
    cycle(2'b11, 0, 0, 0, 0, 1);
    check_reset_now();
    cycle(2'b11, 0, 0, 0, 0, 0);
    run(2'b11, 30);

    // Sync with a simultaneous write: old shadow activates, new stays pending.
    cycle(2'b11, 1, 0, 7, 0, 0);
    cycle(2'b11, 1, 0, 4, 1, 0);
    run(2'b11, 30);

    // Writes on every cycle around wraps of a short period.
    cycle(2'b11, 1, 1, 1, 1, 0);
    for (int k = 0; k < 12; k++) cycle(2'b11, 1, 1, (k % 3) + 1, 0, 0);
    run(2'b11, 20);

    // Largest divisor: counter reaches all-ones and wraps.
    cycle(2'b11, 1, 0, (1 << CW) - 1, 0, 0);
    cycle(2'b11, 0, 0, 0, 1, 0);
    run(2'b01, 8200);

    // Randomized traffic with short divisors so boundaries are frequent.
    cycle(2'b11, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4000; k++) begin
      logic [NUM_CH-1:0] en;
      bit wr, sync, rst;
      int div;
      en[0] = ($urandom_range(0, 9) != 0);
      en[1] = ($urandom_range(0, 9) != 0);
      wr    = ($urandom_range(0, 9) == 0);
      sync  = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      div   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 12);
      cycle(en, wr, $urandom_range(0, NUM_CH - 1), div, sync, rst);
      if (rst) check_reset_now();
    end

    @(negedge i_clk);
    running = 1'b0;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
